// File: rtl/drap_pkg.sv
// Shared DRAP decode constants: opcodes, ALUOp encodings and the bubble word.
package drap_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Decodes as R-type sll $0,$0,0, so a bubble is architecturally harmless.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/drap_main_ctrl.sv
// Combinational opcode-to-control decoder; every output is forced low when valid is low.
module drap_main_ctrl
  import drap_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       valid,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       illegal,
  output logic [1:0] alu_op
);

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    alu_op     = ALU_ADD;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          alu_src    = 1'b1;
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          mem_read   = 1'b1;
        end
        OP_SW: begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
        end
        OP_BEQ: begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
        OP_ADDI: begin
          alu_src   = 1'b1;
          reg_write = 1'b1;
        end
        OP_J:    jump    = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/drap_ifid_decode.sv
// DRAP IF/ID pipeline register with stall/flush, jump-shadow squash, bubble counter and decode.
module drap_ifid_decode #(
  parameter int                 DATA_W   = 32,
  parameter int                 CNT_W    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = drap_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] PC_id,
  output logic [DATA_W-1:0] instr_id,
  output logic              valid_id,
  output logic [29:0]       sign_ext_out,
  output logic [25:0]       jaddr_out,
  output logic              Br_out,
  output logic              jmp_out,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic              RegDst,
  output logic              ALUSrc,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [1:0]        ALUOp,
  output logic              illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] instr_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  bubble_cnt_reg;
  logic [CNT_W-1:0]  bubble_cnt_next;
  logic              squash;

  // The word behind a live jump is the sequential PC+1 fetch; there is no delay slot.
  assign squash = valid_reg && (instr_reg[31:26] == drap_pkg::OP_J);

  assign bubble_cnt_next = (&bubble_cnt_reg) ? bubble_cnt_reg
                                             : bubble_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg         <= '0;
      instr_reg      <= NOP_WORD;
      valid_reg      <= 1'b0;
      bubble_cnt_reg <= '0;
    end else if (flush || (!stall && squash)) begin
      pc_reg         <= PC_in;
      instr_reg      <= NOP_WORD;
      valid_reg      <= 1'b0;
      bubble_cnt_reg <= bubble_cnt_next;
    end else if (!stall) begin
      pc_reg    <= PC_in;
      instr_reg <= instr_in;
      valid_reg <= 1'b1;
    end
  end

  assign PC_id      = pc_reg;
  assign instr_id   = instr_reg;
  assign valid_id   = valid_reg;
  assign bubble_cnt = bubble_cnt_reg;

  assign sign_ext_out = valid_reg ? {{14{instr_reg[15]}}, instr_reg[15:0]} : 30'd0;
  assign jaddr_out    = instr_reg[25:0];
  assign rs           = valid_reg ? instr_reg[25:21] : 5'd0;
  assign rt           = valid_reg ? instr_reg[20:16] : 5'd0;
  assign rd           = valid_reg ? instr_reg[15:11] : 5'd0;

  drap_main_ctrl u_main_ctrl (
    .opcode     (instr_reg[31:26]),
    .valid      (valid_reg),
    .reg_dst    (RegDst),
    .alu_src    (ALUSrc),
    .mem_to_reg (MemtoReg),
    .reg_write  (RegWrite),
    .mem_read   (MemRead),
    .mem_write  (MemWrite),
    .branch     (Br_out),
    .jump       (jmp_out),
    .illegal    (illegal),
    .alu_op     (ALUOp)
  );

endmodule

// File: tb/tb_drap_ifid_decode.sv
// Bench for drap_ifid_decode: directed vector table, counter saturation, randomized run vs reference model.
module tb_drap_ifid_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [31:0] pc_in, instr_in;
  logic [31:0] pc_id, instr_id;
  logic        valid_id, br_out, jmp_out, reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, illegal;
  logic [1:0]  alu_op;
  logic [29:0] sext;
  logic [25:0] jaddr;
  logic [4:0]  rs, rt, rd;
  logic [15:0] cnt;

  drap_ifid_decode #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .PC_in(pc_in), .instr_in(instr_in), .stall(stall), .flush(flush),
    .PC_id(pc_id), .instr_id(instr_id), .valid_id(valid_id), .sign_ext_out(sext),
    .jaddr_out(jaddr), .Br_out(br_out), .jmp_out(jmp_out), .rs(rs), .rt(rt), .rd(rd),
    .RegDst(reg_dst), .ALUSrc(alu_src), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
    .MemRead(mem_read), .MemWrite(mem_write), .ALUOp(alu_op), .illegal(illegal),
    .bubble_cnt(cnt)
  );

  // Narrow-counter instance used only to observe saturation.
  logic        s_rst, s_stall, s_flush;
  logic [31:0] s_pc_in, s_instr_in, s_pc_id, s_instr_id;
  logic        s_valid, s_br, s_jmp, s_regdst, s_alusrc, s_m2r, s_rw, s_mr, s_mw, s_ill;
  logic [1:0]  s_aluop;
  logic [29:0] s_sext;
  logic [25:0] s_jaddr;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [1:0]  s_cnt;

  drap_ifid_decode #(.DATA_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(s_rst), .PC_in(s_pc_in), .instr_in(s_instr_in), .stall(s_stall),
    .flush(s_flush), .PC_id(s_pc_id), .instr_id(s_instr_id), .valid_id(s_valid),
    .sign_ext_out(s_sext), .jaddr_out(s_jaddr), .Br_out(s_br), .jmp_out(s_jmp),
    .rs(s_rs), .rt(s_rt), .rd(s_rd), .RegDst(s_regdst), .ALUSrc(s_alusrc),
    .MemtoReg(s_m2r), .RegWrite(s_rw), .MemRead(s_mr), .MemWrite(s_mw), .ALUOp(s_aluop),
    .illegal(s_ill), .bubble_cnt(s_cnt)
  );

  logic [10:0] dut_ctrl;
  assign dut_ctrl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                     br_out, jmp_out, illegal, alu_op};

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: architectural state of the stage.
  logic [31:0] m_pc, m_instr;
  logic        m_valid;
  int          m_cnt;

  // Control word {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Br,jmp,illegal,ALUOp[1:0]}.
  function automatic logic [10:0] exp_ctrl(input logic [31:0] w, input logic v);
    if (!v) return 11'd0;
    case (w[31:26])
      6'b000000: return 11'b100_100_00_0_10;  // R-type
      6'b100011: return 11'b011_110_00_0_00;  // lw
      6'b101011: return 11'b010_001_00_0_00;  // sw
      6'b000100: return 11'b000_000_10_0_01;  // beq
      6'b001000: return 11'b010_100_00_0_00;  // addi
      6'b000010: return 11'b000_000_01_0_00;  // j
      default:   return 11'b000_000_00_1_00;
    endcase
  endfunction

  function automatic logic [29:0] exp_sext(input logic [31:0] w, input logic v);
    int signed imm;
    imm = $signed(w[15:0]);
    return v ? 30'(imm) : 30'd0;
  endfunction

  task automatic model_step();
    logic bubble;
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
    end else if (!stall || flush) begin
      bubble = flush || (m_valid && m_instr[31:26] == 6'b000010);
      m_pc = pc_in;
      m_instr = bubble ? 32'd0 : instr_in;
      m_valid = !bubble;
      if (bubble && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic compare_model();
    chk("valid_id", valid_id, m_valid);
    chk("PC_id", pc_id, m_pc);
    chk("instr_id", instr_id, m_instr);
    chk("bubble_cnt", cnt, m_cnt);
    chk("controls", dut_ctrl, exp_ctrl(m_instr, m_valid));
    chk("sign_ext_out", sext, exp_sext(m_instr, m_valid));
    chk("jaddr_out", jaddr, m_instr[25:0]);
    chk("rs", rs, m_valid ? m_instr[25:21] : 5'd0);
    chk("rt", rt, m_valid ? m_instr[20:16] : 5'd0);
    chk("rd", rd, m_valid ? m_instr[15:11] : 5'd0);
  endtask

  task automatic apply(input logic r, input logic [31:0] p, input logic [31:0] i,
                       input logic s, input logic f);
    rst = r; pc_in = p; instr_in = i; stall = s; flush = f;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        r;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        st;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    int          e_cnt;
    logic [10:0] e_ctrl;
    logic [29:0] e_sext;
  } vec_t;

  localparam logic [10:0] C_LW   = 11'b011_110_00_0_00;
  localparam logic [10:0] C_J    = 11'b000_000_01_0_00;
  localparam logic [10:0] C_ADDI = 11'b010_100_00_0_00;
  localparam logic [10:0] C_BEQ  = 11'b000_000_10_0_01;
  localparam logic [10:0] C_R    = 11'b100_100_00_0_10;
  localparam logic [10:0] C_ILL  = 11'b000_000_00_1_00;

  vec_t vt[16];
  logic [5:0] ops[7];

  initial begin
    rst = 0; stall = 0; flush = 0; pc_in = 0; instr_in = 0;
    s_rst = 0; s_stall = 0; s_flush = 0; s_pc_in = 0; s_instr_in = 0;
    m_pc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;

    vt[0]  = '{0, 32'h00, 32'h8C22_0004, 0, 0, 0, 32'h00, 32'h0, 0, 11'd0, 30'd0};
    vt[1]  = '{0, 32'h00, 32'h8C22_0004, 0, 0, 0, 32'h00, 32'h0, 0, 11'd0, 30'd0};
    vt[2]  = '{1, 32'h04, 32'h8C22_FFFC, 0, 0, 1, 32'h04, 32'h8C22_FFFC, 0, C_LW, 30'h3FFF_FFFC};
    vt[3]  = '{1, 32'h08, 32'h0800_0040, 0, 0, 1, 32'h08, 32'h0800_0040, 0, C_J, 30'h40};
    vt[4]  = '{1, 32'h09, 32'h2001_0005, 0, 0, 0, 32'h09, 32'h0, 1, 11'd0, 30'd0};
    vt[5]  = '{1, 32'h40, 32'h2001_0007, 0, 0, 1, 32'h40, 32'h2001_0007, 1, C_ADDI, 30'd7};
    vt[6]  = '{1, 32'h41, 32'h1043_0003, 0, 0, 1, 32'h41, 32'h1043_0003, 1, C_BEQ, 30'd3};
    vt[7]  = '{1, 32'h42, 32'hAAAA_5555, 1, 0, 1, 32'h41, 32'h1043_0003, 1, C_BEQ, 30'd3};
    vt[8]  = '{1, 32'h43, 32'h1234_5678, 1, 0, 1, 32'h41, 32'h1043_0003, 1, C_BEQ, 30'd3};
    vt[9]  = '{1, 32'h44, 32'h8C00_0001, 1, 0, 1, 32'h41, 32'h1043_0003, 1, C_BEQ, 30'd3};
    vt[10] = '{1, 32'h50, 32'h0800_0100, 0, 0, 1, 32'h50, 32'h0800_0100, 1, C_J, 30'h100};
    vt[11] = '{1, 32'h51, 32'h2001_0009, 1, 0, 1, 32'h50, 32'h0800_0100, 1, C_J, 30'h100};
    vt[12] = '{1, 32'h52, 32'h2001_0001, 1, 1, 0, 32'h52, 32'h0, 2, 11'd0, 30'd0};
    vt[13] = '{1, 32'h60, 32'hFC00_0000, 0, 0, 1, 32'h60, 32'hFC00_0000, 2, C_ILL, 30'd0};
    vt[14] = '{0, 32'h70, 32'h8C22_0004, 1, 1, 0, 32'h00, 32'h0, 0, 11'd0, 30'd0};
    vt[15] = '{1, 32'h74, 32'h0022_1820, 0, 0, 1, 32'h74, 32'h0022_1820, 0, C_R, 30'h1820};

    for (int k = 0; k < 16; k++) begin
      apply(vt[k].r, vt[k].pc, vt[k].instr, vt[k].st, vt[k].fl);
      chk($sformatf("vec%0d valid", k), valid_id, vt[k].e_valid);
      chk($sformatf("vec%0d PC_id", k), pc_id, vt[k].e_pc);
      chk($sformatf("vec%0d instr_id", k), instr_id, vt[k].e_instr);
      chk($sformatf("vec%0d bubble_cnt", k), cnt, vt[k].e_cnt);
      chk($sformatf("vec%0d controls", k), dut_ctrl, vt[k].e_ctrl);
      chk($sformatf("vec%0d sign_ext", k), sext, vt[k].e_sext);
      if (k == 2) begin
        chk("lw rs", rs, 5'd1);
        chk("lw rt", rt, 5'd2);
      end
      if (k == 3) chk("j jaddr", jaddr, 26'h40);
      $display("vec %0d: pc_id=%h instr_id=%h valid=%b cnt=%0d", k, pc_id, instr_id, valid_id, cnt);
    end

    // Saturation: main stage is held by stall so its model stays in step.
    rst = 1; stall = 1; flush = 0;
    s_rst = 0;
    @(posedge clk); #1;
    s_rst = 1; s_flush = 1;
    for (int n = 1; n <= 5; n++) begin
      s_pc_in = 32'(n);
      @(posedge clk); #1;
      chk($sformatf("sat flush%0d cnt", n), s_cnt, (n > 3) ? 3 : n);
      chk($sformatf("sat flush%0d valid", n), s_valid, 1'b0);
      $display("sat flush %0d: bubble_cnt=%0d", n, s_cnt);
    end
    s_flush = 0;
    compare_model();

    // Randomized run against the reference model.
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    for (int t = 0; t < 400; t++) begin
      logic [31:0] rnd, w;
      logic [5:0]  op;
      rnd = $urandom();
      op  = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      w = {op, rnd[25:0]};
      apply(($urandom_range(0, 39) != 0), $urandom(), w,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      $display("rand %0d: instr_id=%h valid=%b cnt=%0d", t, instr_id, valid_id, cnt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/drap_ifid_decode.md
Name: drap_ifid_decode

Overview:
- IF/ID pipeline stage directly downstream of the DRAP instruction-fetch unit.
- Registers the fetched PC and instruction word, with stall and flush controls, and decodes the registered word.
- Feeds branch, jump, sign-extended offset and jump address back to the fetch unit.
- Feeds datapath control signals forward to the execute stage.
- Squashes the sequential instruction fetched behind a taken jump and counts inserted bubbles.

Parameters:
- DATA_W, 32: PC and instruction width.
- CNT_W, 16: width of the bubble counter.
- NOP_WORD, 32'h0000_0000: word loaded on reset, flush or squash.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- PC_in  in  DATA_W  PC_out from the fetch unit.
- instr_in  in  DATA_W  instruction memory data at PC_in.
- stall  in  1  hold the IF/ID register (hazard unit).
- flush  in  1  kill the IF/ID contents (branch taken in EX).
- PC_id  out  DATA_W  registered PC.
- instr_id  out  DATA_W  registered instruction.
- valid_id  out  1  registered instruction is live.
- sign_ext_out  out  30  sign-extended instr_id[15:0]; drives fetch sign_ext_in.
- jaddr_out  out  26  instr_id[25:0]; drives fetch instruction.
- Br_out  out  1  beq decoded; drives fetch Br_in.
- jmp_out  out  1  j decoded; drives fetch jmp.
- rs, rt, rd  out  5 each  register fields.
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  out  1 each  execute-stage controls.
- ALUOp  out  2  00 add, 01 sub, 10 funct.
- illegal  out  1  valid instruction with unknown opcode.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (rst==0 at posedge):
  - PC_id=0, instr_id=NOP_WORD, valid_id=0, bubble_cnt=0.
  - All decoded outputs evaluate to 0.
- Update priority at each posedge with rst==1: flush > stall > squash > load.
  - flush: instr_id<=NOP_WORD, PC_id<=PC_in, valid_id<=0, bubble_cnt+1.
  - stall: all registers hold; bubble_cnt holds.
  - squash (valid_id && opcode==j, no stall/flush): instr_id<=NOP_WORD, PC_id<=PC_in, valid_id<=0, bubble_cnt+1. This kills the PC+1 word fetched during the jump cycle; there is no delay slot.
  - load: PC_id<=PC_in, instr_id<=instr_in, valid_id<=1.
- bubble_cnt saturates at all-ones and never wraps.
- Decode is combinational from instr_id; every output is ANDed with valid_id.
- Opcode instr_id[31:26] decode:
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 100011 lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 beq: Br_out=1, ALUOp=01.
  - 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - 000010 j: jmp_out=1.
  - any other opcode: all controls 0, illegal=1.
- Width rules: sign_ext_out = {14{instr_id[15]}, instr_id[15:0]}; jaddr_out = instr_id[25:0] unconditionally. rs=[25:21], rt=[20:16], rd=[15:11].
- NOP_WORD decodes as R-type sll $0, which is harmless. Decoded controls are still masked by valid_id=0.
- Stall while a jump is in ID: jmp_out stays high every cycle. The fetch unit reloads the same target, which is idempotent. Squash happens on the first non-stalled edge.
- Flush in the same cycle as a jump in ID: flush wins; the counter increments once.
- Reset mid-stall or mid-flush: reset wins over everything.

Decomposition:
- Shared package drap_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp constants ALU_ADD, ALU_SUB, ALU_FUNCT;
  - NOP_WORD.
- One natural sub-module: drap_main_ctrl, the combinational opcode-to-control decoder. The IF/ID register, squash logic and counter stay in the top.

Test Plan:
- Reset hold: rst=0 for 2 cycles with instr_in=32'h8C22_0004 -> valid_id=0, instr_id=0, RegWrite=0, bubble_cnt=0.
- Load lw: PC_in=4, instr_in=32'h8C22_FFFC -> next cycle valid_id=1, PC_id=4, rs=1, rt=2, MemRead=1, MemtoReg=1, ALUSrc=1, sign_ext_out=30'h3FFF_FFFC.
- Jump squash: load 32'h0800_0040 at PC 8 -> jmp_out=1, jaddr_out=26'h40. Next edge loads NOP_WORD with valid_id=0; bubble_cnt=1. The following edge loads the target instruction normally.
- Stall: load beq 32'h1043_0003, then stall=1 for 3 cycles with instr_in changing -> instr_id, Br_out=1 and sign_ext_out=3 hold; bubble_cnt unchanged.
- Flush priority: flush=1 and stall=1 together while a jump is in ID -> valid_id=0, jmp_out=0 next cycle; bubble_cnt increments by exactly 1.
- Illegal and saturation: instr_in=32'hFC00_0000 -> illegal=1, all controls 0. Then with CNT_W=2, 5 flushes -> bubble_cnt stops at 3.
